// File: rtl/cd_nibble_master.sv
// cd_nibble_master: nibble-bus decoder master; REQ/WE/ADDR/COUNT start a burst, WDATA/WREADY and RDATA/RVALID stream data, nWR/nRD/RS/DOUT/DIN drive the decoder, BUSY/DONE report progress
module cd_nibble_master #(
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int RECOV = 1
) (
  input  logic       CLK_12M,
  input  logic       RESET,
  input  logic       REQ,
  input  logic       WE,
  input  logic [3:0] ADDR,
  input  logic [3:0] COUNT,
  input  logic [3:0] WDATA,
  output logic       WREADY,
  output logic [3:0] RDATA,
  output logic       RVALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       nWR,
  output logic       nRD,
  output logic       RS,
  output logic [3:0] DOUT,
  input  logic [3:0] DIN
);
  typedef enum logic [2:0] {IDLE, A_SETUP, A_STROBE, A_RECOV, D_SETUP, D_STROBE, D_RECOV, FIN} state_t;
  state_t state, nxt;
  logic [2:0] cnt, len;
  logic last, we_r, ph_a, ph_d;
  logic [3:0] idx, rem, wd;
  always_comb begin
    len = (state == A_SETUP || state == D_SETUP) ? 3'(SETUP - 1) :
          (state == A_STROBE || state == D_STROBE) ? 3'(PULSE - 1) : 3'(RECOV - 1);
    last = cnt == len;
  end
  always_ff @(posedge CLK_12M or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      cnt <= 3'd0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? 3'd0 : cnt + 3'd1;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = REQ ? A_SETUP : IDLE;
      A_SETUP:  nxt = last ? A_STROBE : A_SETUP;
      A_STROBE: nxt = last ? A_RECOV : A_STROBE;
      A_RECOV:  nxt = last ? D_SETUP : A_RECOV;
      D_SETUP:  nxt = last ? D_STROBE : D_SETUP;
      D_STROBE: nxt = last ? D_RECOV : D_STROBE;
      // index 0 is never reached by decoder auto-increment, so wrapping onto it forces a fresh address phase
      D_RECOV:  nxt = !last ? D_RECOV : rem == 4'd0 ? FIN : idx == 4'hf ? A_SETUP : D_SETUP;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK_12M or posedge RESET)
    if (RESET) begin
      we_r <= 1'b0;
      idx <= 4'd0;
      rem <= 4'd0;
      wd <= 4'd0;
      RDATA <= 4'd0;
    end else begin
      if (state == IDLE && REQ) begin
        we_r <= WE;
        idx <= ADDR;
        rem <= COUNT;
      end
      if (state == D_RECOV && last && rem != 4'd0) begin
        idx <= idx + 4'd1;
        rem <= rem - 4'd1;
      end
      // write nibble is captured on the edge entering D_SETUP so DOUT is stable for the whole phase
      if (nxt == D_SETUP && state != D_SETUP && we_r) wd <= WDATA;
      if (state == D_STROBE && last && !we_r) RDATA <= DIN;
    end
  always_comb begin
    ph_a = state inside {A_SETUP, A_STROBE, A_RECOV};
    ph_d = state inside {D_SETUP, D_STROBE, D_RECOV};
    RS = ph_d;
    DOUT = ph_a ? idx : (ph_d && we_r) ? wd : 4'd0;
    nWR = !(state == A_STROBE || (state == D_STROBE && we_r));
    nRD = !(state == D_STROBE && !we_r);
    BUSY = state != IDLE;
    DONE = state == FIN;
    WREADY = state == D_SETUP && cnt == 3'd0 && we_r;
    RVALID = state == D_RECOV && cnt == 3'd0 && !we_r;
  end
endmodule

// File: tb/tb_cd_nibble_master.sv
// tb_cd_nibble_master: randomized bench comparing bus activity against a transaction-level model
module tb_cd_nibble_master;
  localparam int S = 1, P = 2, R = 1;
  logic CLK_12M = 1'b0, RESET = 1'b1, REQ = 1'b0, WE = 1'b0;
  logic [3:0] ADDR = 4'd0, COUNT = 4'd0, WDATA, DIN, RDATA, DOUT;
  logic WREADY, RVALID, BUSY, DONE, nWR, nRD, RS;
  logic [3:0] wvals [17], rvals [17];
  int wi = 0, ri = 0;
  logic [5:0] ev [$], exp_ev [$];
  logic [3:0] rd_q [$];
  int busy_cyc = 0, done_cnt = 0, wready_cnt = 0, rvalid_cnt = 0, viol = 0, lowc = 0;
  int n_cmp = 0, n_bad = 0;
  logic pwr = 1'b1, prd = 1'b1, prs = 1'b0;
  logic [3:0] pdout = 4'd0;
  assign WDATA = wvals[wi];
  assign DIN = rvals[ri];
  cd_nibble_master #(.SETUP(S), .PULSE(P), .RECOV(R)) dut (
    .CLK_12M(CLK_12M), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR), .COUNT(COUNT),
    .WDATA(WDATA), .WREADY(WREADY), .RDATA(RDATA), .RVALID(RVALID), .BUSY(BUSY),
    .DONE(DONE), .nWR(nWR), .nRD(nRD), .RS(RS), .DOUT(DOUT), .DIN(DIN)
  );
  always #5 CLK_12M = ~CLK_12M;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge CLK_12M) begin
    if (BUSY) busy_cyc++;
    if (DONE) done_cnt++;
    if (WREADY) begin
      wready_cnt++;
      if (wi < 16) wi++;
    end
    if (RVALID) begin
      rvalid_cnt++;
      rd_q.push_back(RDATA);
    end
    if (!nWR && !nRD) viol++;
    if ((!nWR && pwr) || (!nRD && prd)) ev.push_back({!nWR, RS, DOUT});
    if ((nWR != pwr || nRD != prd || !nWR || !nRD) && {RS, DOUT} != {prs, pdout}) viol++;
    if (!nWR || !nRD) lowc++;
    else if (!pwr || !prd) begin
      if (lowc != P) viol++;
      lowc = 0;
    end
    if (nRD && !prd && ri < 16) ri++;
    pwr = nWR;
    prd = nRD;
    prs = RS;
    pdout = DOUT;
  end
  task automatic tick();
    @(negedge CLK_12M);
    #1;
  endtask
  task automatic clear_mon();
    @(posedge CLK_12M);
    ev.delete();
    rd_q.delete();
    busy_cyc = 0;
    done_cnt = 0;
    wready_cnt = 0;
    rvalid_cnt = 0;
    viol = 0;
    lowc = 0;
    wi = 0;
    ri = 0;
  endtask
  task automatic fill();
    foreach (wvals[i]) begin
      wvals[i] = 4'($urandom);
      rvals[i] = 4'($urandom);
    end
  endtask
  task automatic wait_done(int n, string tag);
    int c = 0;
    while (done_cnt < n && c < 500) begin
      tick();
      c++;
    end
    if (done_cnt < n) check({tag, "_timeout"}, done_cnt, n);
  endtask
  task automatic run_txn(logic we, logic [3:0] addr, logic [3:0] cnt);
    int nph = 0;
    logic [3:0] k;
    exp_ev.delete();
    for (int i = 0; i <= int'(cnt); i++) begin
      k = addr + 4'(i);
      if (i == 0 || k == 4'd0) begin
        exp_ev.push_back({2'b10, k});
        nph++;
      end
      exp_ev.push_back(we ? {2'b11, wvals[i]} : 6'b010000);
      nph++;
    end
    clear_mon();
    tick();
    REQ = 1'b1;
    WE = we;
    ADDR = addr;
    COUNT = cnt;
    tick();
    REQ = 1'b0;
    WE = 1'($urandom);
    ADDR = 4'($urandom);
    COUNT = 4'($urandom);
    wait_done(1, "txn");
    repeat (2) tick();
    check("ev_n", ev.size(), exp_ev.size());
    for (int i = 0; i < ev.size() && i < exp_ev.size(); i++) check($sformatf("ev%0d", i), ev[i], exp_ev[i]);
    check("wready", wready_cnt, we ? int'(cnt) + 1 : 0);
    check("rvalid", rvalid_cnt, we ? 0 : int'(cnt) + 1);
    for (int i = 0; i < rd_q.size() && i <= int'(cnt); i++) check($sformatf("rdata%0d", i), rd_q[i], rvals[i]);
    check("done", done_cnt, 1);
    check("busy_cyc", busy_cyc, nph * (S + P + R) + 1);
    check("viol", viol, 0);
  endtask
  initial begin
    int c;
    fill();
    #12;
    check("rst_nwr", nWR, 1);
    check("rst_nrd", nRD, 1);
    check("rst_rs", RS, 0);
    check("rst_dout", DOUT, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_wready", WREADY, 0);
    check("rst_rvalid", RVALID, 0);
    tick();
    RESET = 1'b0;
    fill();
    wvals[0] = 4'hA;
    run_txn(1'b1, 4'd3, 4'd0);
    fill();
    rvals[0] = 4'd1;
    rvals[1] = 4'd2;
    rvals[2] = 4'd3;
    run_txn(1'b0, 4'd5, 4'd2);
    fill();
    run_txn(1'b1, 4'd14, 4'd3);
    fill();
    run_txn(1'b1, 4'd0, 4'd1);
    fill();
    run_txn(1'b0, 4'd15, 4'd1);
    fill();
    clear_mon();
    tick();
    REQ = 1'b1;
    WE = 1'b1;
    ADDR = 4'd7;
    COUNT = 4'd2;
    tick();
    REQ = 1'b0;
    c = 0;
    while (!(!nWR && RS) && c < 200) begin
      tick();
      c++;
    end
    check("rst_found_dstrobe", !nWR && RS, 1);
    #1 RESET = 1'b1;
    #1;
    check("mid_nwr", nWR, 1);
    check("mid_busy", BUSY, 0);
    check("mid_done", DONE, 0);
    check("mid_rs", RS, 0);
    repeat (2) tick();
    clear_mon();
    tick();
    RESET = 1'b0;
    repeat (20) tick();
    check("post_rst_ev", ev.size(), 0);
    check("post_rst_done", done_cnt, 0);
    check("post_rst_busy", busy_cyc, 0);
    fill();
    run_txn(1'b1, 4'd9, 4'd1);
    fill();
    clear_mon();
    tick();
    REQ = 1'b1;
    WE = 1'b0;
    ADDR = 4'd2;
    COUNT = 4'd0;
    wait_done(1, "hold1");
    check("hold_fin_busy", BUSY, 1);
    check("hold_busy_cyc", busy_cyc, 2 * (S + P + R) + 1);
    tick();
    check("hold_gap_busy", BUSY, 0);
    tick();
    check("hold_restart", BUSY, 1);
    REQ = 1'b0;
    wait_done(2, "hold2");
    repeat (2) tick();
    check("hold_ev", ev.size(), 4);
    check("hold_done", done_cnt, 2);
    repeat (30) begin
      fill();
      run_txn(1'($urandom), 4'($urandom), 4'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cd_nibble_master.md
CD_NIBBLE_MASTER -- requirements
Module: cd_nibble_master

Interface
REQ-001 SHALL have parameter SETUP, default 1, cycles RS/data are stable before a strobe falls (range 1..7).
REQ-002 SHALL have parameter PULSE, default 2, cycles a strobe is held low (range 2..7).
REQ-003 SHALL have parameter RECOV, default 1, cycles strobes are held high after a strobe (range 1..7).
REQ-004 SHALL have port CLK_12M, input, 1, the one clock; all logic on its rising edge.
REQ-005 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port REQ, input, 1, start a transaction; sampled only while BUSY=0.
REQ-007 SHALL have port WE, input, 1, 1=write transaction, 0=read; captured with REQ.
REQ-008 SHALL have port ADDR, input, 4, first register index; captured with REQ.
REQ-009 SHALL have port COUNT, input, 4, number of data nibbles minus one; captured with REQ.
REQ-010 SHALL have port WDATA, input, 4, write nibble for the current data phase.
REQ-011 SHALL have port WREADY, output, 1, one-cycle pulse: WDATA consumed.
REQ-012 SHALL have port RDATA, output, 4, last nibble read; held until next read.
REQ-013 SHALL have port RVALID, output, 1, one-cycle pulse: RDATA updated.
REQ-014 SHALL have port BUSY, output, 1, transaction in progress.
REQ-015 SHALL have port DONE, output, 1, one-cycle pulse on transaction completion.
REQ-016 SHALL have ports nWR, nRD, RS, outputs, 1 each, decoder strobes and register select.
REQ-017 SHALL have port DOUT, output, 4, nibble driven to decoder data input.
REQ-018 SHALL have port DIN, input, 4, nibble returned by decoder.

Function
REQ-019 SHALL run FSM IDLE -> A_SETUP -> A_STROBE -> A_RECOV -> D_SETUP -> D_STROBE -> D_RECOV -> (A_SETUP | D_SETUP | FIN) -> IDLE.
REQ-020 SHALL, in IDLE with REQ=1, capture WE/ADDR/COUNT, load shadow index IDX=ADDR, remaining count REM=COUNT, set BUSY next cycle, enter A_SETUP.
REQ-021 SHALL in address phase drive RS=0, DOUT=IDX, pulse nWR low for PULSE cycles after SETUP cycles; nRD stays 1.
REQ-022 SHALL in data phase drive RS=1; write: DOUT=WDATA latched at D_SETUP entry, nWR strobed; read: nRD strobed, DOUT=0.
REQ-023 SHALL pulse WREADY in the D_SETUP entry cycle of each write data phase.
REQ-024 SHALL latch RDATA=DIN in the last low cycle of nRD and pulse RVALID the following cycle.
REQ-025 SHALL hold RS and DOUT unchanged from setup start through recovery end of each phase.
REQ-026 SHALL after D_RECOV: if REM=0 go FIN; else IDX=IDX+1 mod 16, REM=REM-1, then A_SETUP if new IDX=0, else D_SETUP.
REQ-027 SHALL rationale REQ-026: decoder does not auto-increment at register 0, so index 0 always gets an explicit address phase, incl. wrap 15->0.
REQ-028 SHALL never assert nWR and nRD low simultaneously; strobes change only on setup/strobe/recovery boundaries.
REQ-029 SHALL in FIN pulse DONE for one cycle, clear BUSY, return to IDLE; REQ in FIN cycle ignored.
REQ-030 SHALL ignore REQ, WE, ADDR, COUNT while BUSY=1.
REQ-031 SHALL take exactly (SETUP+PULSE+RECOV) cycles per phase; single-nibble defaults: 8 cycles REQ-to-DONE excluding FIN.

Reset
REQ-032 SHALL on RESET=1 immediately force nWR=1, nRD=1, RS=0, DOUT=0, RDATA=0, BUSY=0, DONE=0, WREADY=0, RVALID=0, FSM=IDLE, IDX=0, REM=0.
REQ-033 SHALL abort any transaction on mid-operation reset with no further strobes or DONE; first REQ after release starts cleanly.

Verification
REQ-034 SHALL cover write ADDR=3, COUNT=0, WDATA=A -> one nWR with RS=0 DOUT=3, one nWR with RS=1 DOUT=A, one WREADY, one DONE.
REQ-035 SHALL cover read ADDR=5, COUNT=2, decoder model returning 1,2,3 -> one address phase, three nRD strobes, RVALID x3, RDATA=1,2,3.
REQ-036 SHALL cover write ADDR=14, COUNT=3 -> address phases before index 14 and index 0 only; data to 14,15,0,1.
REQ-037 SHALL cover ADDR=0, COUNT=1 -> address phase (DOUT=0) before index 0, none before index 1.
REQ-038 SHALL cover RESET asserted during D_STROBE -> nWR=1 same cycle, BUSY=0, no DONE; next REQ completes normally.
REQ-039 SHALL cover REQ held high through a transaction -> new transaction starts only after DONE, in IDLE.
